memory_access: RTL and testbench

Memory-access (MEM) stage of the five-stage MIPS pipeline. Sits directly downstream of the execute stage. Consumes its ALU result, store data, destination register and control bits; performs byte/half/word loads and stores on an internal data memory; registers everything into the MEM/WB pipeline register. Also provides a post-reset memory clear sequence and a debug read port used while the pipeline is halted.

---
 rtl/memory_access.sv | 195 +++++++++++++++++++
 tb/tb_memory_access.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// MEM stage of the five-stage MIPS pipeline.
// Performs byte/half/word loads and stores on an internal word-organised data
// memory and registers the results into the MEM/WB pipeline register. After
// reset the memory is cleared one word per cycle before the stage accepts work.
// A debug read port returns memory words while the pipeline is halted.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag and suppress misaligned
// half/word accesses (o_addr_error, sticky until reset).
//
// state | meaning
// CLEAR | writing zero to word[clr_cnt]; pipeline and debug inputs ignored
// RUN   | normal MEM stage operation, halt/debug handling
module memory_access #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_WB_write,
  input  logic               i_WB_mem_to_reg,
  input  logic               i_MEM_read,
  input  logic               i_MEM_write,
  input  logic [1:0]         i_MEM_size,
  input  logic               i_MEM_unsigned,
  input  logic [NB_REG-1:0]  i_write_reg,
  input  logic [NB_DATA-1:0] i_ALU_result,
  input  logic [NB_DATA-1:0] i_data_to_write,
  input  logic               i_debug_rd_req,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic               o_WB_write,
  output logic               o_WB_mem_to_reg,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic [NB_DATA-1:0] o_ALU_result,
  output logic [NB_DATA-1:0] o_mem_data,
  output logic               o_debug_rd_valid,
  output logic [NB_DATA-1:0] o_debug_data,
  output logic               o_ready,
  output logic               o_addr_error
);

  localparam int DEPTH = 1 << NB_ADDR;
  localparam int LANES = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               clr_we;
  logic [NB_ADDR-1:0] clr_cnt;

  logic [NB_DATA-1:0] mem [DEPTH];

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic               size_byte;
  logic               size_half;
  logic               misaligned;
  logic               run_active;
  logic               store_en;
  logic [LANES-1:0]   byte_en;
  logic [NB_DATA-1:0] wr_data;
  logic [NB_DATA-1:0] rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [NB_DATA-1:0] load_ext;

  assign word_idx   = i_ALU_result[NB_ADDR+1:2];
  assign lane       = i_ALU_result[1:0];
  assign size_byte  = (i_MEM_size == 2'b00);
  assign size_half  = (i_MEM_size == 2'b01);
  assign run_active = (state == RUN) && !i_halt;
  assign o_ready    = (state == RUN);

  // State register for the clear/run sequencer.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= CLEAR;
    else         state <= next_state;
  end

  // Next-state logic: leave CLEAR right after the last word has been zeroed.
  always_comb begin
    next_state = state;
    clr_we     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (&clr_cnt) next_state = RUN;
      end
      RUN:     next_state = RUN;
      default: next_state = CLEAR;
    endcase
  end

  // Clear address counter, restarts from word 0 on every reset.
  always_ff @(posedge i_clk) begin
    if (i_reset)     clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + 1'b1;
  end

  // Misalignment detection; without the check the low address bits are dropped.
  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = (size_half && lane[0]) || (!size_byte && !size_half && (lane != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  // Store lane enables and lane-replicated write data (little-endian).
  always_comb begin
    byte_en = 4'b0000;
    wr_data = i_data_to_write;
    if (size_byte) begin
      byte_en = 4'b0001 << lane;
      wr_data = {LANES{i_data_to_write[7:0]}};
    end else if (size_half) begin
      byte_en = lane[1] ? 4'b1100 : 4'b0011;
      wr_data = {(LANES/2){i_data_to_write[15:0]}};
    end else begin
      byte_en = 4'b1111;
      wr_data = i_data_to_write;
    end
  end

  assign store_en = run_active && i_MEM_write && !misaligned;

  // Memory write port shared by the clear sequence and pipeline stores.
  always_ff @(posedge i_clk) begin
    if (clr_we && !i_reset) begin
      mem[clr_cnt] <= '0;
    end else if (store_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (byte_en[l]) mem[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

  // Load lane selection and sign/zero extension from the pre-store word.
  always_comb begin
    rd_word  = mem[word_idx];
    rd_byte  = rd_word[8*lane +: 8];
    rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_ext = rd_word;
    if (size_byte)
      load_ext = {{(NB_DATA-8){rd_byte[7] & ~i_MEM_unsigned}}, rd_byte};
    else if (size_half)
      load_ext = {{(NB_DATA-16){rd_half[15] & ~i_MEM_unsigned}}, rd_half};
  end

  // MEM/WB pipeline register: loads only when running and not halted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_WB_write      <= 1'b0;
      o_WB_mem_to_reg <= 1'b0;
      o_write_reg     <= '0;
      o_ALU_result    <= '0;
      o_mem_data      <= '0;
    end else if (run_active) begin
      o_WB_write      <= i_WB_write;
      o_WB_mem_to_reg <= i_WB_mem_to_reg;
      o_write_reg     <= i_write_reg;
      o_ALU_result    <= i_ALU_result;
      o_mem_data      <= (i_MEM_read && !misaligned) ? load_ext : '0;
    end
  end

  // Debug read port, serviced only while halted in RUN.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_debug_rd_valid <= 1'b0;
      o_debug_data     <= '0;
    end else begin
      o_debug_rd_valid <= (state == RUN) && i_halt && i_debug_rd_req;
      if ((state == RUN) && i_halt && i_debug_rd_req)
        o_debug_data <= mem[i_debug_addr];
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Sticky misalignment flag for any attempted load or store.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_addr_error <= 1'b0;
    else if (run_active && (i_MEM_read || i_MEM_write) && misaligned)
      o_addr_error <= 1'b1;
  end
`else
  assign o_addr_error = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed plan steps followed by
// random traffic, all compared against a byte-addressed reference model.
module tb_memory_access;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_halt = 1'b0;
  logic        i_WB_write = 1'b0;
  logic        i_WB_mem_to_reg = 1'b0;
  logic        i_MEM_read = 1'b0;
  logic        i_MEM_write = 1'b0;
  logic [1:0]  i_MEM_size = 2'b00;
  logic        i_MEM_unsigned = 1'b0;
  logic [4:0]  i_write_reg = '0;
  logic [31:0] i_ALU_result = '0;
  logic [31:0] i_data_to_write = '0;
  logic        i_debug_rd_req = 1'b0;
  logic [7:0]  i_debug_addr = '0;
  logic        o_WB_write;
  logic        o_WB_mem_to_reg;
  logic [4:0]  o_write_reg;
  logic [31:0] o_ALU_result;
  logic [31:0] o_mem_data;
  logic        o_debug_rd_valid;
  logic [31:0] o_debug_data;
  logic        o_ready;
  logic        o_addr_error;

  memory_access #(.NB_DATA(32), .NB_ADDR(8), .NB_REG(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt),
    .i_WB_write(i_WB_write), .i_WB_mem_to_reg(i_WB_mem_to_reg),
    .i_MEM_read(i_MEM_read), .i_MEM_write(i_MEM_write),
    .i_MEM_size(i_MEM_size), .i_MEM_unsigned(i_MEM_unsigned),
    .i_write_reg(i_write_reg), .i_ALU_result(i_ALU_result),
    .i_data_to_write(i_data_to_write), .i_debug_rd_req(i_debug_rd_req),
    .i_debug_addr(i_debug_addr), .o_WB_write(o_WB_write),
    .o_WB_mem_to_reg(o_WB_mem_to_reg), .o_write_reg(o_write_reg),
    .o_ALU_result(o_ALU_result), .o_mem_data(o_mem_data),
    .o_debug_rd_valid(o_debug_rd_valid), .o_debug_data(o_debug_data),
    .o_ready(o_ready), .o_addr_error(o_addr_error)
  );

  always #5 i_clk = ~i_clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: 1 KiB byte-addressed memory plus expected outputs.
  logic [7:0]  mb [1024];
  logic        exp_wb, exp_m2r, exp_dv, exp_err;
  logic [4:0]  exp_wreg;
  logic [31:0] exp_alu, exp_mem, exp_dd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic mis(input logic [1:0] sz, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    return (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mword(input int byte_base);
    return {mb[byte_base+3], mb[byte_base+2], mb[byte_base+1], mb[byte_base]};
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr[9:0]);
    if (sz == 2'b00) begin
      b = mb[a];
      return uns ? {24'h0, b} : {{24{b[7]}}, b};
    end else if (sz == 2'b01) begin
      h = {mb[(a & ~1) + 1], mb[a & ~1]};
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return mword(a & ~3);
  endfunction

  task automatic mstore(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] d);
    int a;
    a = int'(addr[9:0]);
    if (sz == 2'b00) begin
      mb[a] = d[7:0];
    end else if (sz == 2'b01) begin
      mb[a & ~1] = d[7:0];
      mb[(a & ~1) + 1] = d[15:8];
    end else begin
      for (int k = 0; k < 4; k++) mb[(a & ~3) + k] = d[8*k +: 8];
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_wb"},    {31'h0, o_WB_write}, {31'h0, exp_wb});
    chk({tag, "_m2r"},   {31'h0, o_WB_mem_to_reg}, {31'h0, exp_m2r});
    chk({tag, "_wreg"},  {27'h0, o_write_reg}, {27'h0, exp_wreg});
    chk({tag, "_alu"},   o_ALU_result, exp_alu);
    chk({tag, "_mem"},   o_mem_data, exp_mem);
    chk({tag, "_dv"},    {31'h0, o_debug_rd_valid}, {31'h0, exp_dv});
    chk({tag, "_dd"},    o_debug_data, exp_dd);
    chk({tag, "_ready"}, {31'h0, o_ready}, 32'h1);
    chk({tag, "_err"},   {31'h0, o_addr_error}, {31'h0, exp_err});
  endtask

  task automatic op(input string tag, input logic h, rd, wr, input logic [1:0] sz,
                    input logic uns, input logic [31:0] addr, data,
                    input logic [4:0] wreg, input logic wb, m2r, dreq,
                    input logic [7:0] daddr);
    logic m;
    if (!h) begin
      m = mis(sz, addr);
      exp_wb = wb; exp_m2r = m2r; exp_wreg = wreg; exp_alu = addr;
      exp_mem = (rd && !m) ? mload(addr, sz, uns) : 32'h0;
      if ((rd || wr) && m) exp_err = 1'b1;
      if (wr && !m) mstore(addr, sz, data);
      exp_dv = 1'b0;
    end else begin
      exp_dv = dreq;
      if (dreq) exp_dd = mword(int'(daddr) * 4);
    end
    i_halt = h; i_MEM_read = rd; i_MEM_write = wr; i_MEM_size = sz;
    i_MEM_unsigned = uns; i_ALU_result = addr; i_data_to_write = data;
    i_write_reg = wreg; i_WB_write = wb; i_WB_mem_to_reg = m2r;
    i_debug_rd_req = dreq; i_debug_addr = daddr;
    @(posedge i_clk); #1;
    check_all(tag);
  endtask

  task automatic rand_inputs();
    i_halt = 1'($urandom); i_MEM_read = 1'($urandom); i_MEM_write = 1'b1;
    i_MEM_size = 2'($urandom); i_MEM_unsigned = 1'($urandom);
    i_ALU_result = $urandom; i_data_to_write = $urandom;
    i_write_reg = 5'($urandom); i_WB_write = 1'b1; i_WB_mem_to_reg = 1'b1;
    i_debug_rd_req = 1'b1; i_debug_addr = 8'($urandom);
  endtask

  task automatic reset_and_clear();
    int cycles;
    rand_inputs();
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    for (int k = 0; k < 1024; k++) mb[k] = 8'h00;
    exp_wb = 0; exp_m2r = 0; exp_wreg = 0; exp_alu = 0; exp_mem = 0;
    exp_dv = 0; exp_dd = 0; exp_err = 0;
    chk("rst_ready", {31'h0, o_ready}, 32'h0);
    chk("rst_alu", o_ALU_result, 32'h0);
    chk("rst_dd", o_debug_data, 32'h0);
    chk("rst_err", {31'h0, o_addr_error}, 32'h0);
    cycles = 0;
    while (!o_ready && cycles < 300) begin
      rand_inputs();
      @(posedge i_clk); #1;
      cycles++;
      chk("clr_wb", {31'h0, o_WB_write}, 32'h0);
      chk("clr_dv", {31'h0, o_debug_rd_valid}, 32'h0);
    end
    chk("clr_cycles", 32'(cycles), 32'd256);
    i_MEM_write = 1'b0; i_MEM_read = 1'b0; i_debug_rd_req = 1'b0;
  endtask

  task automatic rand_op();
    logic [31:0] hi;
    hi = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FC00) : 32'h0;
    op("rnd", ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
       1'($urandom), hi | 32'($urandom_range(0, 127)), $urandom, 5'($urandom),
       1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 31)));
  endtask

  initial begin
    reset_and_clear();

    op("dbg7f", 1, 0, 0, 2'b11, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 8'h7F);
    chk("dbg7f_valid", {31'h0, o_debug_rd_valid}, 32'h1);
    chk("dbg7f_data", o_debug_data, 32'h0);
    op("dbg_b2b_a", 1, 0, 0, 2'b11, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 8'h10);
    op("dbg_b2b_b", 1, 0, 0, 2'b11, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 8'h11);
    op("dbg_none", 1, 0, 0, 2'b11, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 8'h00);

    op("sw10", 0, 0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 0, 8'h0);
    op("lw10", 0, 1, 0, 2'b11, 0, 32'h10, 32'h0, 5'd9, 1, 0, 0, 8'h0);
    chk("plan_lw10", o_mem_data, 32'hDEADBEEF);
    chk("plan_wreg9", {27'h0, o_write_reg}, 32'd9);
    chk("plan_wb1", {31'h0, o_WB_write}, 32'h1);
    op("sb13", 0, 0, 1, 2'b00, 0, 32'h13, 32'h80, 5'd0, 0, 0, 0, 8'h0);
    op("lb13", 0, 1, 0, 2'b00, 0, 32'h13, 32'h0, 5'd2, 1, 0, 0, 8'h0);
    chk("plan_lb13", o_mem_data, 32'hFFFFFF80);
    op("lbu13", 0, 1, 0, 2'b00, 1, 32'h13, 32'h0, 5'd2, 1, 0, 0, 8'h0);
    chk("plan_lbu13", o_mem_data, 32'h00000080);
    op("lw10b", 0, 1, 0, 2'b11, 0, 32'h10, 32'h0, 5'd2, 1, 0, 0, 8'h0);
    chk("plan_lw10b", o_mem_data, 32'h80ADBEEF);
    op("lh12", 0, 1, 0, 2'b01, 0, 32'h12, 32'h0, 5'd3, 1, 0, 0, 8'h0);
    chk("plan_lh12", o_mem_data, 32'hFFFF80AD);
    op("lhu12", 0, 1, 0, 2'b01, 1, 32'h12, 32'h0, 5'd3, 1, 0, 0, 8'h0);
    chk("plan_lhu12", o_mem_data, 32'h000080AD);
    op("lh10", 0, 1, 0, 2'b01, 0, 32'h10, 32'h0, 5'd3, 1, 0, 0, 8'h0);
    chk("plan_lh10", o_mem_data, 32'hFFFFBEEF);
    op("lw_size10", 0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd4, 1, 1, 0, 8'h0);

    op("rw30", 0, 1, 1, 2'b11, 0, 32'h30, 32'h12345678, 5'd5, 1, 0, 0, 8'h0);
    chk("plan_rw30_pre", o_mem_data, 32'h0);
    op("lw30", 0, 1, 0, 2'b11, 0, 32'h30, 32'h0, 5'd5, 1, 0, 0, 8'h0);
    chk("plan_lw30", o_mem_data, 32'h12345678);

    op("halt_sw20", 1, 0, 1, 2'b11, 0, 32'h20, 32'h5, 5'd7, 1, 1, 0, 8'h0);
    chk("plan_halt_hold", o_mem_data, 32'h12345678);
    op("halt_dbg8", 1, 0, 0, 2'b11, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 8'h08);
    chk("plan_dbg8", o_debug_data, 32'h0);
    op("lw20", 0, 1, 0, 2'b11, 0, 32'h20, 32'h0, 5'd6, 1, 0, 0, 8'h0);
    chk("plan_lw20", o_mem_data, 32'h0);
    op("dbg_nohalt", 0, 0, 0, 2'b11, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 8'h04);

    op("lw11", 0, 1, 0, 2'b11, 0, 32'h11, 32'h0, 5'd8, 1, 0, 0, 8'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("plan_lw11_zero", o_mem_data, 32'h0);
    chk("plan_lw11_err", {31'h0, o_addr_error}, 32'h1);
`endif
    op("sw22", 0, 0, 1, 2'b11, 0, 32'h22, 32'hAAAA5555, 5'd0, 0, 0, 0, 8'h0);
    op("dbg8b", 1, 0, 0, 2'b11, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 8'h08);
    op("lh11", 0, 1, 0, 2'b01, 0, 32'h11, 32'h0, 5'd8, 1, 0, 0, 8'h0);
    op("idle", 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 8'h0);

    op("sw_wrap", 0, 0, 1, 2'b11, 0, 32'hABCD_0440, 32'hCAFEF00D, 5'd0, 0, 0, 0, 8'h0);
    op("lw_wrap", 0, 1, 0, 2'b11, 0, 32'h0000_0040, 32'h0, 5'd1, 1, 0, 0, 8'h0);
    chk("plan_wrap", o_mem_data, 32'hCAFEF00D);

    for (int n = 0; n < 400; n++) rand_op();

    reset_and_clear();
    op("lw10_reclr", 0, 1, 0, 2'b11, 0, 32'h10, 32'h0, 5'd9, 1, 0, 0, 8'h0);
    chk("plan_reclr", o_mem_data, 32'h0);
    for (int n = 0; n < 100; n++) rand_op();

    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge i_clk); #1;
    end
    chk("midclr_ready", {31'h0, o_ready}, 32'h0);
    reset_and_clear();
    for (int n = 0; n < 150; n++) rand_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
